// File: rtl/prio_result_capture.sv
// prio_result_capture
// Re-aligns each launched lane vector with the priority-tree root result
// (prio_y_i, prio_err_i) LAT cycles later. It encodes the lowest valid lane
// and queues {idx, err} in a first-word-fall-through FIFO. A credit rule keeps
// the total of in-flight launches plus queued results within DEPTH, so a
// completing result always has a free slot.
// Optional build macro: PRIO_CAP_ONEHOT_CHECK_EN adds a one-hot and parity
// cross-check of the delayed lane vector against the tree result.
module prio_result_capture #(
  parameter int N     = 8,
  parameter int IDXW  = 3,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int ECW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            launch_valid_i,
  output logic            launch_ready_o,
  input  logic [N-1:0]    lane_vec_i,
  input  logic            prio_y_i,
  input  logic            prio_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [IDXW-1:0] out_idx_o,
  output logic            out_err_o,
  output logic [ECW-1:0]  err_count_o,
  output logic            err_ovf_o,
  input  logic            err_clr_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LAT-1:0]  vld_q;
  logic [N-1:0]    vec_q [LAT];
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IDXW:0]   mem_q [DEPTH];
  logic [ECW-1:0]  err_cnt_q, err_cnt_d;
  logic            err_ovf_q, err_ovf_d;

  logic            accept, complete, push, pop;
  logic [N-1:0]    done_vec;
  logic [IDXW-1:0] res_idx;
  logic            res_err;

  assign launch_ready_o = ({1'b0, inflight_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH);
  assign accept         = launch_valid_i & launch_ready_o;
  assign complete       = vld_q[LAT-1];
  assign done_vec       = vec_q[LAT-1];
  assign push           = complete;
  assign pop            = out_valid_o & out_ready_i;

  // Valid bits of the launch delay line; cleared by reset so in-flight work is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Lane-vector payload of the delay line, qualified by vld_q.
  // NOTE: payload and FIFO storage are not reset; their valid bits and counts are, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (accept) vec_q[0] <= lane_vec_i;
    for (int i = 1; i < LAT; i++) vec_q[i] <= vec_q[i-1];
  end

  // Encode the lowest set lane of the completing vector and form its error flag.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    res_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (done_vec[i]) res_idx = IDXW'(i);
    end
`ifdef PRIO_CAP_ONEHOT_CHECK_EN
    res_err = prio_err_i | ~prio_y_i
            | ($countones(done_vec) != 1)
            | (prio_y_i != ^done_vec);
`else
    res_err = prio_err_i | ~prio_y_i;
`endif
  end

  // Next-state for the in-flight counter, FIFO occupancy and pointers.
  // NOTE: combinational logic uses blocking '=', clocked state uses non-blocking '<='.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !complete)      inflight_d = inflight_q + CW'(1);
    else if (!accept && complete) inflight_d = inflight_q - CW'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  // Counter and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage write; the credit rule guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {res_idx, res_err};
  end

  assign out_valid_o = (cnt_q != '0);
  assign out_idx_o   = out_valid_o ? mem_q[rd_ptr_q][IDXW:1] : '0;
  assign out_err_o   = out_valid_o ? mem_q[rd_ptr_q][0]      : 1'b0;

  // Saturating error counter with sticky overflow; a clear beats a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_ovf_d = err_ovf_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
      err_ovf_d = 1'b0;
    end else if (push && res_err) begin
      if (err_cnt_q == '1) err_ovf_d = 1'b1;
      else                 err_cnt_d = err_cnt_q + ECW'(1);
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign err_count_o = err_cnt_q;
  assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_prio_result_capture.sv
// Testbench for prio_result_capture: a default-width DUT and an ECW=2 DUT
// share one stimulus stream. A transaction-level model (queues of launches and
// results, plus an integer error tally) predicts every output on each cycle.
// Directed steps with literal expectations pin the model itself.
module tb_prio_result_capture;

  localparam int N     = 8;
  localparam int IDXW  = 3;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int ECW   = 8;
  localparam int MAX8  = 255;
  localparam int MAX2  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic launch_valid = 1'b0;
  logic [N-1:0] lane_vec = '0;
  logic prio_y = 1'b0;
  logic prio_err = 1'b0;
  logic out_ready = 1'b0;
  logic err_clr = 1'b0;

  logic            launch_ready, out_valid, out_err, err_ovf;
  logic [IDXW-1:0] out_idx;
  logic [ECW-1:0]  err_count;
  logic            launch_ready2, out_valid2, out_err2, err_ovf2;
  logic [IDXW-1:0] out_idx2;
  logic [1:0]      err_count2;

  always #5 clk = ~clk;

  prio_result_capture #(.N(N), .IDXW(IDXW), .LAT(LAT), .DEPTH(DEPTH), .ECW(ECW)) dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid_i(launch_valid), .launch_ready_o(launch_ready), .lane_vec_i(lane_vec),
    .prio_y_i(prio_y), .prio_err_i(prio_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx), .out_err_o(out_err),
    .err_count_o(err_count), .err_ovf_o(err_ovf), .err_clr_i(err_clr)
  );

  prio_result_capture #(.N(N), .IDXW(IDXW), .LAT(LAT), .DEPTH(DEPTH), .ECW(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .launch_valid_i(launch_valid), .launch_ready_o(launch_ready2), .lane_vec_i(lane_vec),
    .prio_y_i(prio_y), .prio_err_i(prio_err),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_idx_o(out_idx2), .out_err_o(out_err2),
    .err_count_o(err_count2), .err_ovf_o(err_ovf2), .err_clr_i(err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int         c;
    logic [N-1:0] vec;
    logic       y;
    logic       e;
  } launch_t;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic            err;
  } res_t;

  launch_t pend[$];
  res_t    rq[$];
  int      errn = 0;
  int      cyc  = 0;
  logic    ovr_en = 1'b0, ovr_y = 1'b0, ovr_e = 1'b0;
  launch_t ml;
  res_t    mr;
  bit      m_acc, m_perr;

  function automatic res_t expect_res(input launch_t l);
    res_t r;
    r.idx = '0;
    for (int i = 0; i < N; i++) begin
      if (l.vec[i]) begin
        r.idx = IDXW'(i);
        break;
      end
    end
    r.err = l.e | ~l.y;
`ifdef PRIO_CAP_ONEHOT_CHECK_EN
    r.err = r.err | ($countones(l.vec) != 1) | (l.y != ^l.vec);
`endif
    return r;
  endfunction

  function automatic bit exp_ready();
    return (pend.size() + rq.size()) < DEPTH;
  endfunction

  // Model update on each clock edge; reset discards everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      rq.delete();
      errn = 0;
    end else begin
      m_acc = launch_valid && exp_ready();
      if (rq.size() != 0 && out_ready) mr = rq.pop_front();
      m_perr = 1'b0;
      if (pend.size() != 0 && pend[0].c + LAT == cyc) begin
        ml = pend.pop_front();
        mr = expect_res(ml);
        rq.push_back(mr);
        m_perr = mr.err;
      end
      if (err_clr) errn = 0;
      else if (m_perr) errn++;
      if (m_acc) pend.push_back('{c: cyc, vec: lane_vec,
                                  y: ovr_en ? ovr_y : ^lane_vec,
                                  e: ovr_en ? ovr_e : 1'b0});
      cyc++;
    end
  end

  // Tree root model: drives the stored result in a completion cycle, noise otherwise.
  always @(posedge clk) begin
    #2;
    if (pend.size() != 0 && pend[0].c + LAT == cyc) begin
      prio_y   = pend[0].y;
      prio_err = pend[0].e;
    end else begin
      prio_y   = 1'($urandom);
      prio_err = 1'($urandom);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_err_ovf", err_ovf, 0);
      check("rst_err_count2", err_count2, 0);
    end else begin
      check("launch_ready", launch_ready, exp_ready());
      check("out_valid", out_valid, rq.size() != 0);
      if (rq.size() != 0) begin
        check("out_idx", out_idx, rq[0].idx);
        check("out_err", out_err, rq[0].err);
      end
      check("err_count", err_count, (errn > MAX8) ? MAX8 : errn);
      check("err_ovf", err_ovf, errn > MAX8);
      check("err_count2", err_count2, (errn > MAX2) ? MAX2 : errn);
      check("err_ovf2", err_ovf2, errn > MAX2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N-1:0] v, input logic ov, input logic y, input logic e);
    launch_valid = 1'b1;
    lane_vec     = v;
    ovr_en       = ov;
    ovr_y        = y;
    ovr_e        = e;
  endtask

  task automatic idle();
    launch_valid = 1'b0;
    ovr_en       = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single launch: result visible LAT+1 cycles after launch.
    launch(8'b0001_0000, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    check("t1_not_yet", out_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_idx", out_idx, 4);
    check("t1_err", out_err, 0);
    check("t1_cnt", err_count, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back launches fill the credit; drain in order.
    for (int i = 0; i < 4; i++) begin
      launch(N'(1 << i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    launch(8'b1000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_blocked", launch_ready, 0);
    repeat (4) tick();
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_idx0", out_idx, 0);
    check("t2_still_blocked", launch_ready, 0);
    tick();
    @(negedge clk);
    check("t2_idx1", out_idx, 1);
    check("t2_ready_back", launch_ready, 1);
    tick();
    @(negedge clk);
    check("t2_idx2", out_idx, 2);
    tick();
    @(negedge clk);
    check("t2_idx3", out_idx, 3);
    tick();
    @(negedge clk);
    check("t2_empty", out_valid, 0);
    out_ready = 1'b0;

    // Errored result counts; a clear in the push cycle wins.
    launch(8'b0000_0100, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    repeat (LAT) tick();
    @(negedge clk);
    check("t3_idx", out_idx, 2);
    check("t3_err", out_err, 1);
    check("t3_cnt1", err_count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    launch(8'b0010_0000, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    repeat (LAT - 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t3_clr_wins", err_count, 0);
    check("t3_err2", out_err, 1);
    check("t3_idx2", out_idx, 5);
    out_ready = 1'b1;
    tick();

    // Four errored results: 2-bit counter saturates at 3 with overflow.
    for (int i = 0; i < 4; i++) begin
      launch(N'(1 << (i + 2)), 1'b1, 1'b1, 1'b1);
      tick();
    end
    idle();
    repeat (LAT + 1) tick();
    @(negedge clk);
    check("t4_cnt2_sat", err_count2, 3);
    check("t4_ovf2", err_ovf2, 1);
    check("t4_cnt8", err_count, 4);
    check("t4_ovf8", err_ovf, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_clr_cnt2", err_count2, 0);
    check("t4_clr_ovf2", err_ovf2, 0);
    out_ready = 1'b0;

    // Two lanes set with a clean tree result.
    launch(8'b0000_0011, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    repeat (LAT) tick();
    @(negedge clk);
    check("t5_idx", out_idx, 0);
`ifdef PRIO_CAP_ONEHOT_CHECK_EN
    check("t5_err_chk", out_err, 1);
`else
    check("t5_err_nochk", out_err, 0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset with one queued result and two launches in flight.
    launch(8'b0100_0000, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    repeat (LAT) tick();
    launch(8'b0000_0010, 1'b0, 1'b0, 1'b0);
    tick();
    launch(8'b0000_1000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_cnt_nz", err_count != 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_cnt", err_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("t6_no_stale", out_valid, 0);
    check("t6_cnt_zero", err_count, 0);
    check("t6_ready", launch_ready, 1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
